// File: rtl/bsg_parallel_in_serial_out_traffic_node_pkg.sv
// bsg_piso_traffic_pkg
// Shared definitions for the serialisation traffic node: TX state encoding,
// the flit-to-slot mapping used by the RX assembler, and the packet
// generator value function.
package bsg_piso_traffic_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

  // Flit idx of a packet occupies slot flit_slot() (counted in link_width_p units
  // from the LS end); hi_to_lo sends the MS slice first.
  function automatic int unsigned flit_slot(int unsigned idx, int unsigned els, bit hi_to_lo);
    return hi_to_lo ? (els - 1 - idx) : idx;
  endfunction

  // Packet n, channel c carries n + c; the caller truncates to the channel width,
  // which gives the modulo-2^channel_width wrap.
  function automatic logic [31:0] gen_value(logic [31:0] n, logic [31:0] c);
    return n + c;
  endfunction

endpackage

// File: rtl/bsg_parallel_in_serial_out_traffic_node_if.sv
// bsg_parallel_in_serial_out_traffic_node_if
// One direction-bundle of the ready/valid link: {v, data, ready_and_rev}.
// The node drives all three fields on its outgoing bundle (v/data = TX flit,
// ready_and_rev = RX ready) and reads all three on its incoming bundle.
//   master : drives v, data, ready_and_rev
//   slave  : reads  v, data, ready_and_rev
interface bsg_parallel_in_serial_out_traffic_node_if #(parameter int width_p = 8);
  logic               v;
  logic [width_p-1:0] data;
  logic               ready_and_rev;

  modport master (output v, output data, output ready_and_rev);
  modport slave  (input  v, input  data, input  ready_and_rev);
endinterface

// File: rtl/bsg_parallel_in_serial_out_traffic_node_gen.sv
// bsg_piso_traffic_gen
// Packet generator: holds a 32-bit packet index and presents packet idx as
// num_channels_p channels, channel 0 in the LS bits. yumi_i consumes the
// current packet and advances to the next.
// Ports:
//   clk_i, reset_i  clock, async active-low reset (index returns to 0)
//   yumi_i          advance to the next packet
//   data_o          current packet
module bsg_piso_traffic_gen
  import bsg_piso_traffic_pkg::*;
#(
  parameter int num_channels_p  = 4,
  parameter int channel_width_p = 8
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      yumi_i,
  output logic [num_channels_p*channel_width_p-1:0] data_o
);

  logic [31:0] idx_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) idx_q <= '0;
    else if (yumi_i) idx_q <= idx_q + 32'd1;
  end

  always_comb begin
    data_o = '0;
    for (int c = 0; c < num_channels_p; c++)
      data_o[c*channel_width_p +: channel_width_p] = channel_width_p'(gen_value(idx_q, 32'(c)));
  end

endmodule

// File: rtl/bsg_parallel_in_serial_out_traffic_node.sv
// bsg_parallel_in_serial_out_traffic_node
// Self-checking serialisation traffic node. TX generates packets of
// num_channels_p x channel_width_p bits and sends them link_width_p bits per
// flit; RX reassembles incoming flits and checks each packet against its own
// copy of the generator.
// Ports:
//   clk_i, reset_i       clock, async active-low reset
//   en_i                 TX enable, honoured only at packet boundaries
//   num_packets_i        packets to send (0 = unbounded)
//   gap_every_i          one idle cycle after every N sent packets (0 = none)
//   link_i / link_o      ready/valid link in / out (link_o.ready_and_rev = RX ready)
//   sent_o, received_o   packet counters (wrap at 2^32)
//   error_o, error_count_o, first_err_idx_o   mismatch status
//   done_o               bounded run finished and TX idle
//
// TX state | meaning
// ---------+-----------------------------------------------------
// TX_IDLE  | nothing in flight; loads the next packet when enabled
// TX_SEND  | link_o.v high, current flit held until accepted
// TX_GAP   | one idle cycle after every gap_every_i packets
module bsg_parallel_in_serial_out_traffic_node
  import bsg_piso_traffic_pkg::*;
#(
  parameter int num_channels_p  = 4,
  parameter int channel_width_p = 8,
  parameter int link_width_p    = 8,
  parameter bit hi_to_lo_p      = 1'b0,
  parameter int err_cnt_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       en_i,
  input  logic [31:0]                num_packets_i,
  input  logic [3:0]                 gap_every_i,
  bsg_parallel_in_serial_out_traffic_node_if.slave  link_i,
  bsg_parallel_in_serial_out_traffic_node_if.master link_o,
  output logic [31:0]                sent_o,
  output logic [31:0]                received_o,
  output logic                       error_o,
  output logic [err_cnt_width_p-1:0] error_count_o,
  output logic [31:0]                first_err_idx_o,
  output logic                       done_o
);

  localparam int width_lp  = num_channels_p * channel_width_p;
  localparam int els_lp    = width_lp / link_width_p;
  localparam int lg_els_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
  localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_lp - 1);

  // ---------------- TX ----------------
  tx_state_e             state_q, state_d;
  logic [width_lp-1:0]   sr_q, sr_d;
  logic [lg_els_lp-1:0]  tx_idx_q, tx_idx_d;
  logic [31:0]           sent_q, sent_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic [width_lp-1:0]   tx_gen_data;
  logic                  tx_gen_yumi, tx_xfer, tx_last, done_now, done_next, gap_hit;

  // The TX generator is consumed when a packet is loaded, so its output is
  // always the next packet to send and back-to-back loads need no lookahead.
  bsg_piso_traffic_gen #(.num_channels_p(num_channels_p), .channel_width_p(channel_width_p)) tx_gen (
    .clk_i(clk_i), .reset_i(reset_i), .yumi_i(tx_gen_yumi), .data_o(tx_gen_data)
  );

  assign tx_xfer   = (state_q == TX_SEND) & link_i.ready_and_rev;
  assign tx_last   = (tx_idx_q == last_idx_lp);
  assign done_now  = (num_packets_i != 32'd0) & (sent_q == num_packets_i);
  assign done_next = (num_packets_i != 32'd0) & ((sent_q + 32'd1) == num_packets_i);
  assign gap_hit   = (gap_every_i != 4'd0) & (({1'b0, gap_cnt_q} + 5'd1) == {1'b0, gap_every_i});

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    tx_idx_d    = tx_idx_q;
    sent_d      = sent_q;
    gap_cnt_d   = gap_cnt_q;
    tx_gen_yumi = 1'b0;
    unique case (state_q)
      TX_SEND: begin
        if (tx_xfer) begin
          if (tx_last) begin
            sent_d    = sent_q + 32'd1;
            tx_idx_d  = '0;
            gap_cnt_d = (gap_hit || gap_every_i == 4'd0) ? 4'd0 : gap_cnt_q + 4'd1;
            if (gap_hit) begin
              state_d = TX_GAP;
            end else if (en_i && !done_next) begin
              sr_d        = tx_gen_data;
              tx_gen_yumi = 1'b1;
            end else begin
              state_d = TX_IDLE;
            end
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            sr_d     = hi_to_lo_p ? (sr_q << link_width_p) : (sr_q >> link_width_p);
          end
        end
      end
      // TX_IDLE and TX_GAP share the same load rule; GAP just never lingers.
      default: begin
        state_d = TX_IDLE;
        if (en_i && !done_now) begin
          sr_d        = tx_gen_data;
          tx_gen_yumi = 1'b1;
          tx_idx_d    = '0;
          state_d     = TX_SEND;
        end
      end
    endcase
  end

  // ---------------- RX ----------------
  logic                       rx_full_q, rx_full_d;
  logic [lg_els_lp-1:0]       rx_idx_q, rx_idx_d;
  logic [width_lp-1:0]        asm_q, asm_d;
  logic [31:0]                recv_q, recv_d, first_q, first_d;
  logic                       err_q, err_d;
  logic [err_cnt_width_p-1:0] err_cnt_q, err_cnt_d;
  logic [width_lp-1:0]        ref_data;
  logic                       rx_xfer;
  int unsigned                rx_slot;

  bsg_piso_traffic_gen #(.num_channels_p(num_channels_p), .channel_width_p(channel_width_p)) rx_ref (
    .clk_i(clk_i), .reset_i(reset_i), .yumi_i(rx_full_q), .data_o(ref_data)
  );

  assign rx_xfer = link_i.v & ~rx_full_q;
  assign rx_slot = flit_slot(32'(rx_idx_q), els_lp, hi_to_lo_p);

  always_comb begin
    rx_full_d = 1'b0;
    rx_idx_d  = rx_idx_q;
    asm_d     = asm_q;
    recv_d    = recv_q;
    first_d   = first_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (rx_xfer) begin
      asm_d[rx_slot*link_width_p +: link_width_p] = link_i.data;
      if (rx_idx_q == last_idx_lp) begin
        rx_idx_d  = '0;
        rx_full_d = 1'b1;
      end else begin
        rx_idx_d = rx_idx_q + 1'b1;
      end
    end
    // Compare cycle: RX is not ready, so asm_q is stable here.
    if (rx_full_q) begin
      recv_d = recv_q + 32'd1;
      if (asm_q != ref_data) begin
        err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        if (!err_q) first_d = recv_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= TX_IDLE;
      sr_q      <= '0;
      tx_idx_q  <= '0;
      sent_q    <= '0;
      gap_cnt_q <= '0;
      rx_full_q <= 1'b0;
      rx_idx_q  <= '0;
      asm_q     <= '0;
      recv_q    <= '0;
      first_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      tx_idx_q  <= tx_idx_d;
      sent_q    <= sent_d;
      gap_cnt_q <= gap_cnt_d;
      rx_full_q <= rx_full_d;
      rx_idx_q  <= rx_idx_d;
      asm_q     <= asm_d;
      recv_q    <= recv_d;
      first_q   <= first_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign link_o.v    = (state_q == TX_SEND);
  assign link_o.data = hi_to_lo_p ? sr_q[width_lp-1 -: link_width_p] : sr_q[link_width_p-1:0];
  // Gated by reset so the link reads not-ready while the node is held in reset.
  assign link_o.ready_and_rev = reset_i & ~rx_full_q;

  assign sent_o          = sent_q;
  assign received_o      = recv_q;
  assign error_o         = err_q;
  assign error_count_o   = err_cnt_q;
  assign first_err_idx_o = first_q;
  assign done_o          = done_now & (state_q != TX_SEND);

endmodule

// File: tb/tb_bsg_parallel_in_serial_out_traffic_node.sv
module tb_bsg_parallel_in_serial_out_traffic_node;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b0, en = 1'b0, rst1_n = 1'b0, en1 = 1'b0, gate = 1'b1;
  logic [31:0] num_pk = 32'd0, num1 = 32'd0;
  logic [3:0]  gap_every = 4'd0, gap1 = 4'd0;
  logic [31:0] sent, recv, ferr, sent1, recv1, ferr1;
  logic        err, done, err1, done1;
  logic [15:0] ecnt, ecnt1;
  logic [7:0]  mask_now = 8'h00;

  int checks = 0;
  int errors = 0;

  bsg_parallel_in_serial_out_traffic_node_if #(.width_p(8))  tx_if ();
  bsg_parallel_in_serial_out_traffic_node_if #(.width_p(8))  rx_if ();
  bsg_parallel_in_serial_out_traffic_node_if #(.width_p(16)) lb_if ();

  // Loopback through the bench: gate stalls both sides of the handshake alike,
  // mask_now flips bits of the flit on its way to RX.
  assign rx_if.v             = tx_if.v & gate;
  assign rx_if.data          = tx_if.data ^ mask_now;
  assign rx_if.ready_and_rev = tx_if.ready_and_rev & gate;

  bsg_parallel_in_serial_out_traffic_node #(
    .num_channels_p(4), .channel_width_p(8), .link_width_p(8), .hi_to_lo_p(1'b0), .err_cnt_width_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en), .num_packets_i(num_pk), .gap_every_i(gap_every),
    .link_i(rx_if), .link_o(tx_if), .sent_o(sent), .received_o(recv), .error_o(err),
    .error_count_o(ecnt), .first_err_idx_o(ferr), .done_o(done)
  );

  bsg_parallel_in_serial_out_traffic_node #(
    .num_channels_p(4), .channel_width_p(8), .link_width_p(16), .hi_to_lo_p(1'b1), .err_cnt_width_p(16)
  ) dut_lb (
    .clk_i(clk), .reset_i(rst1_n), .en_i(en1), .num_packets_i(num1), .gap_every_i(gap1),
    .link_i(lb_if), .link_o(lb_if), .sent_o(sent1), .received_o(recv1), .error_o(err1),
    .error_count_o(ecnt1), .first_err_idx_o(ferr1), .done_o(done1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: packet n, channel c = (n + c) mod 256, channel 0 LS.
  function automatic logic [31:0] pkt_word(int unsigned n);
    logic [31:0] w;
    w = '0;
    for (int c = 0; c < 4; c++) w[8*c +: 8] = 8'((n + c) % 256);
    return w;
  endfunction

  logic [7:0]  exp_q[$];
  logic [15:0] exp1_q[$];

  task automatic push_pkts(input int n);
    logic [31:0] w;
    for (int p = 0; p < n; p++) begin
      w = pkt_word(p);
      for (int f = 0; f < 4; f++) exp_q.push_back(w[8*f +: 8]);
    end
  endtask

  task automatic push_pkts_lb(input int n);
    logic [31:0] w;
    for (int p = 0; p < n; p++) begin
      w = pkt_word(p);
      exp1_q.push_back(w[31:16]);
      exp1_q.push_back(w[15:0]);
    end
  endtask

  // Link stall pattern: 0 = always ready, 1 = toggling, 2 = random.
  int gate_mode = 0;
  always @(posedge clk) begin
    #1;
    case (gate_mode)
      1:       gate = ~gate;
      2:       gate = ($urandom_range(0, 3) != 0);
      default: gate = 1'b1;
    endcase
  end

  // Monitor / scoreboard for the main node.
  int         flit_cnt = 0;
  int         gchk = 0;
  bit         prev_stall = 1'b0, gap_chk_en = 1'b0, corrupt_en = 1'b0;
  logic [7:0] prev_data = 8'h00, corrupt_bits = 8'h00;
  int         corrupt_flit = 0;

  always @(negedge clk) begin
    logic [7:0] expf;
    if (!reset_i) begin
      flit_cnt   = 0;
      prev_stall = 1'b0;
      gchk       = 0;
      mask_now   = 8'h00;
    end else begin
      if (gchk == 2) begin
        chk("gap_idle_v", tx_if.v, 1'b0);
        gchk = 1;
      end else if (gchk == 1) begin
        chk("gap_resume_v", tx_if.v, 1'b1);
        gchk = 0;
      end
      if (prev_stall) begin
        chk("hold_v", tx_if.v, 1'b1);
        chk("hold_data", tx_if.data, prev_data);
      end
      mask_now = (corrupt_en && tx_if.v && flit_cnt == corrupt_flit) ? corrupt_bits : 8'h00;
      if (tx_if.v && rx_if.ready_and_rev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL flit_extra actual=%0h required=none", tx_if.data);
        end else begin
          expf = exp_q.pop_front();
          chk("flit_data", tx_if.data, expf);
        end
        flit_cnt++;
        if (gap_chk_en && (flit_cnt % 4) == 0) gchk = ((flit_cnt / 4) % 2 == 0) ? 2 : 1;
      end
      prev_stall = tx_if.v && !rx_if.ready_and_rev;
      prev_data  = tx_if.data;
    end
  end

  // Monitor for the hi_to_lo loopback node.
  int          cnt1 = 0;
  logic [15:0] first1 = 16'h0000;
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst1_n) cnt1 = 0;
    else if (lb_if.v && lb_if.ready_and_rev) begin
      if (cnt1 == 0) first1 = lb_if.data;
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lb_flit_extra actual=%0h required=none", lb_if.data);
      end else begin
        e = exp1_q.pop_front();
        chk("lb_flit_data", lb_if.data, e);
      end
      cnt1++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_i    = 1'b0;
    en         = 1'b0;
    corrupt_en = 1'b0;
    gap_chk_en = 1'b0;
    gate_mode  = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset_i = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int n_flits, input int budget);
    int i;
    bit early;
    i = 0;
    early = 1'b0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
      if (done && flit_cnt != n_flits) early = 1'b1;
    end
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_done_flits"}, early, 1'b0);
  endtask

  task automatic check_run(input string nm, input int n, input int n_err, input int first);
    repeat (6) @(negedge clk);
    chk({nm, "_sent"}, sent, n);
    chk({nm, "_received"}, recv, n);
    chk({nm, "_error"}, err, n_err != 0);
    chk({nm, "_error_count"}, ecnt, n_err);
    chk({nm, "_first_err_idx"}, ferr, first);
    chk({nm, "_flits_left"}, exp_q.size(), 0);
    chk({nm, "_tx_idle"}, tx_if.v, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int p, f, b, fc, i;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_v", tx_if.v, 1'b0);
    chk("rst_ready", tx_if.ready_and_rev, 1'b0);
    chk("rst_sent", sent, 0);
    chk("rst_received", recv, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", err, 1'b0);

    // Plain loopback, 16 packets; hi_to_lo node runs alongside.
    do_reset();
    push_pkts(16);
    push_pkts_lb(4);
    num_pk = 32'd16;
    num1   = 32'd4;
    rst1_n = 1'b1;
    en     = 1'b1;
    en1    = 1'b1;
    wait_done("loop16", 64, 500);
    chk("loop16_flit_cnt", flit_cnt, 64);
    check_run("loop16", 16, 0, 0);
    chk("lb_first_flit", first1, 16'h0302);
    chk("lb_done", done1, 1'b1);
    chk("lb_sent", sent1, 4);
    chk("lb_received", recv1, 4);
    chk("lb_error", err1, 1'b0);
    chk("lb_flits_left", exp1_q.size(), 0);

    // Toggling peer ready.
    do_reset();
    push_pkts(8);
    num_pk    = 32'd8;
    gate_mode = 1;
    en        = 1'b1;
    wait_done("toggle", 32, 800);
    check_run("toggle", 8, 0, 0);

    // Corrupt bit 0 of flit 1 of packet 5.
    do_reset();
    push_pkts(8);
    num_pk       = 32'd8;
    corrupt_flit = 5 * 4 + 1;
    corrupt_bits = 8'h01;
    corrupt_en   = 1'b1;
    en           = 1'b1;
    wait_done("corrupt5", 32, 500);
    check_run("corrupt5", 8, 1, 5);

    // Random stalls with one random corruption.
    do_reset();
    push_pkts(12);
    p = $urandom_range(0, 11);
    f = $urandom_range(0, 3);
    b = $urandom_range(0, 7);
    num_pk       = 32'd12;
    corrupt_flit = p * 4 + f;
    corrupt_bits = 8'(1 << b);
    corrupt_en   = 1'b1;
    gate_mode    = 2;
    en           = 1'b1;
    wait_done("rand", 48, 1500);
    check_run("rand", 12, 1, p);

    // Gap every 2 packets, unbounded, then drop en mid-packet.
    do_reset();
    push_pkts(40);
    num_pk     = 32'd0;
    gap_every  = 4'd2;
    gap_chk_en = 1'b1;
    en         = 1'b1;
    i = 0;
    while (flit_cnt < 24 && i < 500) begin @(negedge clk); i++; end
    chk("gap_progress", flit_cnt >= 24, 1'b1);
    gap_chk_en = 1'b0;
    i = 0;
    while ((flit_cnt % 4) != 2 && i < 50) begin @(negedge clk); i++; end
    en = 1'b0;
    i = 0;
    while ((flit_cnt % 4) != 0 && i < 50) begin @(negedge clk); i++; end
    chk("gap_pkt_complete", flit_cnt % 4, 0);
    fc = flit_cnt;
    repeat (6) @(negedge clk);
    chk("gap_idle_flits", flit_cnt, fc);
    chk("gap_idle_v", tx_if.v, 1'b0);
    chk("gap_sent", sent, fc / 4);
    chk("gap_received", recv, fc / 4);
    chk("gap_error", err, 1'b0);
    chk("gap_unbounded_done", done, 1'b0);
    gap_every = 4'd0;

    // Async reset mid-packet, then a fresh run of 4 packets.
    do_reset();
    push_pkts(8);
    num_pk = 32'd8;
    en     = 1'b1;
    i = 0;
    while (flit_cnt < 6 && i < 100) begin @(negedge clk); i++; end
    chk("mid_sent_before", sent, 1);
    #2;
    reset_i = 1'b0;
    #1;
    chk("mid_rst_sent", sent, 0);
    chk("mid_rst_received", recv, 0);
    chk("mid_rst_v", tx_if.v, 1'b0);
    chk("mid_rst_ready", tx_if.ready_and_rev, 1'b0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    push_pkts(4);
    num_pk  = 32'd4;
    reset_i = 1'b1;
    wait_done("fresh4", 16, 300);
    check_run("fresh4", 4, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
